// File: rtl/vector_mem_ctrl.sv
// vector_mem_ctrl: row memory controller for the SIMD lane datapath.
//
// Owns a 2**ADDR_WIDTH x (DATA_WIDTH*NUM_ELEMENTS) row memory and runs burst
// commands against it:
//   FETCH - streams paired operand rows A/B out through an OUT_DEPTH FIFO
//           over a valid/ready handshake with backpressure.
//   STORE - writes result rows back with a per-element write mask.
// Beat i of a burst addresses base + i*stride (mod 2**ADDR_WIDTH).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op                   0=FETCH, 1=STORE
//   cmd_addr_a/b/r           FETCH operand bases / STORE base
//   cmd_len, cmd_stride      burst rows minus 1, address step per row
//   wr_valid/wr_ready        store beat handshake, wr_data + wr_mask
//   rd_valid/rd_ready        fetch beat handshake, row_a/row_b/rd_last
//   busy                     controller not idle
//
// state | meaning
// IDLE  | accepting a command
// FETCH | issuing paired reads, one per cycle while FIFO has room
// DRAIN | all reads issued, waiting for the last-tagged beat to pop
// STORE | accepting write beats
module vector_mem_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_ELEMENTS = 4,
  parameter int LEN_WIDTH    = 4,
  parameter int OUT_DEPTH    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_op,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr_a,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr_b,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr_r,
  input  logic [LEN_WIDTH-1:0]               cmd_len,
  input  logic [ADDR_WIDTH-1:0]              cmd_stride,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] wr_data,
  input  logic [NUM_ELEMENTS-1:0]            wr_mask,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [DATA_WIDTH*NUM_ELEMENTS-1:0] row_a,
  output logic [DATA_WIDTH*NUM_ELEMENTS-1:0] row_b,
  output logic                               rd_last,
  output logic                               busy
);

  localparam int ROW_W = DATA_WIDTH * NUM_ELEMENTS;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = $clog2(OUT_DEPTH);
  localparam int CW    = $clog2(OUT_DEPTH + 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(OUT_DEPTH - 1);
  localparam logic [CW:0]   OCC_LIM = (CW + 1)'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, STORE} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] cur_a_q, cur_b_q, cur_r_q, stride_q;
  logic [LEN_WIDTH-1:0]  len_q, idx_q;

  logic [ROW_W-1:0] mem [DEPTH];
  logic [ROW_W-1:0] rd_a_q, rd_b_q;
  logic             rd_tag_q, inflight_q;

  logic [ROW_W-1:0] fifo_a [OUT_DEPTH];
  logic [ROW_W-1:0] fifo_b [OUT_DEPTH];
  logic             fifo_l [OUT_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic           cmd_fire, wr_fire, issue, pop, beat_last, can_issue, head_last;
  logic [CW:0]    occ;

  assign beat_last = (idx_q == len_q);
  assign rd_valid  = (count_q != '0);
  assign pop       = rd_valid && rd_ready;
  assign head_last = fifo_l[rd_ptr_q];
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_fire   = wr_valid && wr_ready;

  // Occupancy the FIFO will have after this edge if nothing new is issued;
  // an issue now lands in the FIFO two edges later, so this bounds overflow.
  assign occ       = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
  assign can_issue = (occ < OCC_LIM);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_op ? STORE : FETCH;
      FETCH:   if (can_issue && beat_last) state_d = DRAIN;
      DRAIN:   if (pop && head_last) state_d = IDLE;
      STORE:   if (wr_valid && beat_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    issue     = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE:    cmd_ready = !rst;
      FETCH:   issue     = can_issue;
      STORE:   wr_ready  = !rst;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      len_q    <= '0;
      stride_q <= '0;
      cur_a_q  <= '0;
      cur_b_q  <= '0;
      cur_r_q  <= '0;
    end else if (cmd_fire) begin
      idx_q    <= '0;
      len_q    <= cmd_len;
      stride_q <= cmd_stride;
      cur_a_q  <= cmd_addr_a;
      cur_b_q  <= cmd_addr_b;
      cur_r_q  <= cmd_addr_r;
    end else if (issue || wr_fire) begin
      idx_q   <= idx_q + 1'b1;
      cur_a_q <= cur_a_q + stride_q;
      cur_b_q <= cur_b_q + stride_q;
      cur_r_q <= cur_r_q + stride_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int k = 0; k < NUM_ELEMENTS; k++) begin
        if (wr_mask[k]) mem[cur_r_q][k*DATA_WIDTH +: DATA_WIDTH] <= wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      rd_a_q   <= mem[cur_a_q];
      rd_b_q   <= mem[cur_b_q];
      rd_tag_q <= beat_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= issue;
  end

  always_ff @(posedge clk) begin
    if (inflight_q) begin
      fifo_a[wr_ptr_q] <= rd_a_q;
      fifo_b[wr_ptr_q] <= rd_b_q;
      fifo_l[wr_ptr_q] <= rd_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (inflight_q) wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
      if (pop)        rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(inflight_q) - CW'(pop);
    end
  end

  // Empty FIFO presents zeros rather than stale head contents.
  assign row_a   = rd_valid ? fifo_a[rd_ptr_q] : '0;
  assign row_b   = rd_valid ? fifo_b[rd_ptr_q] : '0;
  assign rd_last = rd_valid && fifo_l[rd_ptr_q];

endmodule

// File: tb/tb_vector_mem_ctrl.sv
// Self-checking bench for vector_mem_ctrl: directed test-plan steps followed
// by random bursts, checked against a row-array model of the memory.
module tb_vector_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_op;
  logic [9:0]   cmd_addr_a, cmd_addr_b, cmd_addr_r, cmd_stride;
  logic [3:0]   cmd_len;
  logic         wr_valid, wr_ready;
  logic [127:0] wr_data;
  logic [3:0]   wr_mask;
  logic         rd_valid, rd_ready, rd_last, busy;
  logic [127:0] row_a, row_b;

  int checks   = 0;
  int failures = 0;

  logic [127:0] mem_model [1024];
  logic [127:0] st_rows [16];
  logic [3:0]   st_masks [16];
  logic [127:0] first_a, first_b;

  vector_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_r(cmd_addr_r),
    .cmd_len(cmd_len), .cmd_stride(cmd_stride),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .row_a(row_a), .row_b(row_b),
    .rd_last(rd_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int baddr(input logic [9:0] base, input int i, input logic [9:0] stride);
    return (int'(base) + i * int'(stride)) % 1024;
  endfunction

  task automatic issue_cmd(input logic op, input logic [9:0] a, input logic [9:0] b,
                           input logic [9:0] r, input logic [3:0] len, input logic [9:0] stride);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk("cmd_ready_idle", 128'(cmd_ready), 128'(1));
    cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_addr_r = r;
    cmd_len = len; cmd_stride = stride; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_addr_a = 10'($urandom); cmd_addr_b = 10'($urandom); cmd_addr_r = 10'($urandom);
    chk("busy_after_cmd", 128'(busy), 128'(1));
    chk("cmd_ready_busy", 128'(cmd_ready), 128'(0));
  endtask

  task automatic do_store(input logic [9:0] base, input logic [3:0] len,
                          input logic [9:0] stride, input bit gaps);
    int a;
    issue_cmd(1'b1, 10'($urandom), 10'($urandom), base, len, stride);
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          wr_valid = 1'b0;
          step();
        end
      end
      wr_valid = 1'b1;
      wr_data  = st_rows[i];
      wr_mask  = st_masks[i];
      chk("wr_ready", 128'(wr_ready), 128'(1));
      step();
      a = baddr(base, i, stride);
      for (int k = 0; k < 4; k++)
        if (st_masks[i][k]) mem_model[a][k*32 +: 32] = st_rows[i][k*32 +: 32];
    end
    wr_valid = 1'b0;
    chk("store_done_idle", 128'(busy), 128'(0));
  endtask

  task automatic do_fetch(input logic [9:0] a, input logic [9:0] b, input logic [3:0] len,
                          input logic [9:0] stride, input bit rnd);
    logic [127:0] qa[$];
    logic [127:0] qb[$];
    logic         ql[$];
    logic [127:0] prev_a, prev_b;
    bit           seen, stalled;
    int           cyc, beats;
    for (int i = 0; i <= int'(len); i++) begin
      qa.push_back(mem_model[baddr(a, i, stride)]);
      qb.push_back(mem_model[baddr(b, i, stride)]);
      ql.push_back(i == int'(len));
    end
    issue_cmd(1'b0, a, b, 10'($urandom), len, stride);
    // stray store beats during a fetch must be ignored
    wr_valid = 1'b1;
    wr_data  = {$urandom, $urandom, $urandom, $urandom};
    wr_mask  = 4'hF;
    cyc = 1; beats = 0; seen = 0; stalled = 0;
    while (beats <= int'(len) && cyc < 300) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid) begin
        if (!seen) begin
          chk("first_latency", 128'(cyc), 128'(3));
          seen = 1;
          first_a = row_a;
          first_b = row_b;
        end
        if (stalled) begin
          chk("stall_hold_a", row_a, prev_a);
          chk("stall_hold_b", row_b, prev_b);
        end
        chk("row_a", row_a, qa[0]);
        chk("row_b", row_b, qb[0]);
        chk("rd_last", 128'(rd_last), 128'(ql[0]));
        prev_a = row_a;
        prev_b = row_b;
        stalled = !rd_ready;
        if (rd_ready) begin
          void'(qa.pop_front());
          void'(qb.pop_front());
          void'(ql.pop_front());
          beats++;
        end
      end else if (seen && !rnd) begin
        chk("no_bubble", 128'(rd_valid), 128'(1));
      end
      step();
      cyc++;
    end
    chk("fetch_beats", 128'(beats), 128'(int'(len) + 1));
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    chk("fetch_done_idle", 128'(busy), 128'(0));
    chk("fetch_done_empty", 128'(rd_valid), 128'(0));
  endtask

  initial begin
    logic [9:0] ra, rb, rs;
    logic [3:0] rl;
    int         cyc, beats;

    rst = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_addr_a = 0; cmd_addr_b = 0; cmd_addr_r = 0;
    cmd_len = 0; cmd_stride = 0; wr_valid = 0; wr_data = 0; wr_mask = 0; rd_ready = 0;
    repeat (3) step();
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_rd_last", 128'(rd_last), 128'(0));
    chk("rst_wr_ready", 128'(wr_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_row_a", row_a, 128'(0));
    chk("rst_row_b", row_b, 128'(0));
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 128'(cmd_ready), 128'(1));

    // fill the whole memory so every later fetch has defined contents
    for (int j = 0; j < 64; j++) begin
      for (int i = 0; i < 16; i++) begin
        st_rows[i]  = {$urandom, $urandom, $urandom, $urandom};
        st_masks[i] = 4'hF;
      end
      do_store(10'(j * 16), 4'd15, 10'd1, 1'b0);
    end

    // basic store then paired fetch
    for (int i = 0; i < 4; i++) begin
      st_rows[i]  = {4{32'(i + 1)}};
      st_masks[i] = 4'hF;
    end
    do_store(10'h010, 4'd3, 10'd1, 1'b0);
    do_fetch(10'h010, 10'h012, 4'd1, 10'd1, 1'b0);
    chk("basic_first_a", first_a, {4{32'd1}});
    chk("basic_first_b", first_b, {4{32'd3}});

    // full-length burst, no backpressure
    do_fetch(10'h040, 10'h1C0, 4'd15, 10'd1, 1'b0);
    // random backpressure
    do_fetch(10'h080, 10'h300, 4'd7, 10'd3, 1'b1);

    // address wrap
    for (int i = 0; i < 4; i++) begin
      st_rows[i]  = {4{32'hC0DE_0000 + 32'(i)}};
      st_masks[i] = 4'hF;
    end
    do_store(10'h3FE, 4'd3, 10'd1, 1'b0);
    do_fetch(10'h3FE, 10'h000, 4'd3, 10'd1, 1'b0);
    chk("wrap_row0", first_b, {4{32'hC0DE_0002}});

    // masked write
    st_rows[0] = {4{32'hAAAA_AAAA}}; st_masks[0] = 4'hF;
    do_store(10'h050, 4'd0, 10'd0, 1'b0);
    st_rows[0] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    st_masks[0] = 4'b0101;
    do_store(10'h050, 4'd0, 10'd0, 1'b0);
    do_fetch(10'h050, 10'h050, 4'd0, 10'd0, 1'b0);
    chk("mask_keep_e1", 128'(first_a[63:32]), 128'(32'hAAAA_AAAA));
    chk("mask_keep_e3", 128'(first_a[127:96]), 128'(32'hAAAA_AAAA));
    chk("mask_new_e0", 128'(first_a[31:0]), 128'(32'h0000_0000));
    chk("mask_new_e2", 128'(first_a[95:64]), 128'(32'h2222_2222));

    // zero-stride store: last beat's masked elements win
    for (int i = 0; i < 3; i++) begin
      st_rows[i]  = {$urandom, $urandom, $urandom, $urandom};
      st_masks[i] = 4'($urandom);
    end
    do_store(10'h060, 4'd2, 10'd0, 1'b1);
    do_fetch(10'h060, 10'h061, 4'd0, 10'd0, 1'b0);

    // reset in the middle of a fetch
    issue_cmd(1'b0, 10'h100, 10'h200, 10'h0, 4'd7, 10'd1);
    rd_ready = 1'b1;
    beats = 0; cyc = 0;
    while (!(beats == 2 && rd_valid) && cyc < 50) begin
      if (rd_valid) beats++;
      step();
      cyc++;
    end
    chk("mid_rst_beat3", row_a, mem_model[10'h102]);
    rst = 1'b1;
    step();
    chk("mid_rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_cmd_ready", 128'(cmd_ready), 128'(0));
    chk("mid_rst_row_a", row_a, 128'(0));
    rst = 1'b0;
    rd_ready = 1'b0;
    #1;
    chk("mid_rst_release", 128'(cmd_ready), 128'(1));
    repeat (3) step();
    chk("mid_rst_no_stray", 128'(rd_valid), 128'(0));
    do_fetch(10'h100, 10'h200, 4'd7, 10'd1, 1'b0);

    // random mixed traffic
    for (int t = 0; t < 24; t++) begin
      ra = 10'($urandom);
      rb = 10'($urandom);
      rl = 4'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          st_rows[i]  = {$urandom, $urandom, $urandom, $urandom};
          st_masks[i] = 4'($urandom);
        end
        do_store(ra, rl, rs, 1'b1);
        do_fetch(ra, rb, rl, rs, 1'($urandom_range(0, 1)));
      end else begin
        do_fetch(ra, rb, rl, rs, 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
